// File: rtl/decode_stage.sv
// Instruction decode stage: decodes an RV32 subset and buffers results in a
// two-entry skid buffer between fetch and execute handshakes.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] imm,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        use_imm,
  output logic        use_pc,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_imm;
    logic        use_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } dec_t;

  state_t state_q, state_d;
  dec_t   dec, main_q, skid_q;
  logic   acc, pop, load_main, load_skid, main_from_skid, bad;
  logic [6:0] opc, f7;
  logic [2:0] f3;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // Decode happens on the fetch side so buffered entries hold final fields.
  always_comb begin
    dec         = '0;
    bad         = 1'b0;
    dec.pc      = in_pc;
    dec.funct3  = f3;
    dec.rs1     = in_instr[19:15];
    dec.rd      = in_instr[11:7];
    dec.use_imm = 1'b1;
    case (opc)
      OP_IMM: begin
        dec.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.reg_write = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          dec.imm    = {27'd0, in_instr[24:20]};
          dec.funct7 = f7;
        end
        bad = (f3 == 3'd1 && f7 != 7'h00) ||
              (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_REG: begin
        dec.use_imm   = 1'b0;
        dec.funct7    = f7;
        dec.rs2       = in_instr[24:20];
        dec.reg_write = 1'b1;
        bad = (f7 != 7'h00 && f7 != 7'h20 && f7 != 7'h01) ||
              (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ||
              (f7 == 7'h01 && f3 != 3'd0 && f3 != 3'd4 && f3 != 3'd6);
      end
      LUI, AUIPC: begin
        dec.imm       = {in_instr[31:12], 12'h000};
        dec.rs1       = 5'd0;
        dec.use_pc    = (opc == AUIPC);
        dec.reg_write = 1'b1;
      end
      LOAD: begin
        dec.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      STORE: begin
        dec.imm       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.rs2       = in_instr[24:20];
        dec.rd        = 5'd0;
        dec.mem_write = 1'b1;
        bad = (f3 > 3'd2);
      end
      default: bad = 1'b1;
    endcase
    dec.opcode  = opc;
    dec.illegal = bad;
    if (bad) begin
      dec.opcode    = 7'h00;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
    end
  end

  assign acc       = in_valid && in_ready;
  assign out_valid = (state_q != EMPTY);
  assign pop       = out_valid && out_ready;

  // Skid buffer control; flush overrides any accept or pop in the same cycle.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (acc && !pop) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (!acc && pop) begin
            state_d = EMPTY;
          end else if (acc && pop) begin
            load_main = 1'b1;
          end
        end
        TWO: if (pop) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= dec;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec;
    end
  end

  assign out_pc     = main_q.pc;
  assign alu_opcode = main_q.opcode;
  assign alu_funct3 = main_q.funct3;
  assign alu_funct7 = main_q.funct7;
  assign imm        = main_q.imm;
  assign rs1_addr   = main_q.rs1;
  assign rs2_addr   = main_q.rs2;
  assign rd_addr    = main_q.rd;
  assign use_imm    = main_q.use_imm;
  assign use_pc     = main_q.use_pc;
  assign reg_write  = main_q.reg_write;
  assign mem_read   = main_q.mem_read;
  assign mem_write  = main_q.mem_write;
  assign illegal    = main_q.illegal;

endmodule
